// File: rtl/rf_wport_arbiter.sv
// rf_wport_arbiter: arbitrates the register-file write port between primary writeback and a 2-deep secondary FIFO.
// Define ARB_STARVE_GUARD_EN to enable the wait counter that stalls the primary to force a secondary slot.
module rf_wport_arbiter #(
    parameter int WIDTH    = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             p_we,
    input  logic [4:0]       p_wa,
    input  logic [WIDTH-1:0] p_wd,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [4:0]       s_wa,
    input  logic [WIDTH-1:0] s_wd,
    output logic             p_stall,
    output logic             rf_we,
    output logic [4:0]       rf_wa,
    output logic [WIDTH-1:0] rf_wd,
    output logic [1:0]       pend_cnt
);
    logic [1:0][4:0]       wa_q, wa_d;
    logic [1:0][WIDTH-1:0] wd_q, wd_d;
    logic [1:0]            cnt_q, cnt_d;
    logic                  rf_we_q, rf_we_d;
    logic [4:0]            rf_wa_q, rf_wa_d;
    logic [WIDTH-1:0]      rf_wd_q, rf_wd_d;
    logic                  p_req, head_g, p_g, acc, pos;

    if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_bad_max_wait
        $error("MAX_WAIT must be in 1..15");
    end

    assign s_ready  = cnt_q != 2'd2;
    assign pend_cnt = cnt_q;
    assign rf_we    = rf_we_q;
    assign rf_wa    = rf_wa_q;
    assign rf_wd    = rf_wd_q;
    assign p_req    = p_we && p_wa != 5'd0;
    assign head_g   = cnt_q != 2'd0 && (p_stall || !p_req);
    assign p_g      = p_req && !head_g;
    assign acc      = s_valid && s_ready && s_wa != 5'd0;
    // Enqueue slot: acceptance implies cnt_q <= 1, so a head dequeue always frees slot 0.
    assign pos      = cnt_q[0] && !head_g;

`ifdef ARB_STARVE_GUARD_EN
    logic [3:0] wait_q, wait_d;

    assign p_stall = wait_q == 4'(MAX_WAIT) && cnt_q != 2'd0;
    assign wait_d  = (cnt_q == 2'd0 || head_g) ? 4'd0 :
                     (wait_q == 4'(MAX_WAIT)) ? wait_q : wait_q + 4'd1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) wait_q <= 4'd0;
        else          wait_q <= wait_d;
    end
`else
    assign p_stall = 1'b0;
`endif

    always_comb begin
        wa_d = wa_q;
        wd_d = wd_q;
        if (head_g) begin
            wa_d[0] = wa_q[1];
            wd_d[0] = wd_q[1];
        end
        if (acc) begin
            wa_d[pos] = s_wa;
            wd_d[pos] = s_wd;
        end
        cnt_d   = cnt_q - {1'b0, head_g} + {1'b0, acc};
        rf_we_d = head_g || p_g;
        rf_wa_d = head_g ? wa_q[0] : p_g ? p_wa : rf_wa_q;
        rf_wd_d = head_g ? wd_q[0] : p_g ? p_wd : rf_wd_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wa_q    <= '0;
            wd_q    <= '0;
            cnt_q   <= 2'd0;
            rf_we_q <= 1'b0;
            rf_wa_q <= 5'd0;
            rf_wd_q <= '0;
        end else begin
            wa_q    <= wa_d;
            wd_q    <= wd_d;
            cnt_q   <= cnt_d;
            rf_we_q <= rf_we_d;
            rf_wa_q <= rf_wa_d;
            rf_wd_q <= rf_wd_d;
        end
    end
endmodule

// File: tb/tb_rf_wport_arbiter.sv
// tb_rf_wport_arbiter: scoreboard bench comparing rf_wport_arbiter against a queue-based reference model.
module tb_rf_wport_arbiter;
    localparam int W  = 32;
    localparam int MW = 4;
`ifdef ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    typedef struct packed {
        logic [4:0]   wa;
        logic [W-1:0] wd;
    } ent_t;

    typedef struct {
        logic         we;
        logic [4:0]   wa;
        logic [W-1:0] wd;
        logic [1:0]   pend;
        logic         rdy;
        logic         stall;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset_n = 1'b1;
    logic         p_we = 1'b0, s_valid = 1'b0;
    logic [4:0]   p_wa = '0, s_wa = '0;
    logic [W-1:0] p_wd = '0, s_wd = '0;
    logic         s_ready, p_stall, rf_we;
    logic [4:0]   rf_wa;
    logic [W-1:0] rf_wd;
    logic [1:0]   pend_cnt;

    ent_t         m_q[$];
    exp_t         sb[$];
    int           m_wait = 0;
    logic         m_we = 1'b0;
    logic [4:0]   m_wa = '0;
    logic [W-1:0] m_wd = '0;
    int           errors = 0, checks = 0;
    logic         acc;

    rf_wport_arbiter #(.WIDTH(W), .MAX_WAIT(MW)) dut (
        .clk(clk), .reset_n(reset_n),
        .p_we(p_we), .p_wa(p_wa), .p_wd(p_wd),
        .s_valid(s_valid), .s_ready(s_ready), .s_wa(s_wa), .s_wd(s_wd),
        .p_stall(p_stall), .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
        .pend_cnt(pend_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Applies one cycle of inputs, advances the model across the next edge and queues the expected result.
    task automatic cyc(input logic pwe, input logic [4:0] pwa, input logic [W-1:0] pwd,
                       input logic sv, input logic [4:0] swa, input logic [W-1:0] swd,
                       output logic accepted);
        bit   stall, hg, pg;
        int   n;
        exp_t e;
        p_we = pwe; p_wa = pwa; p_wd = pwd;
        s_valid = sv; s_wa = swa; s_wd = swd;
        n = m_q.size();
        stall = GUARD && m_wait == MW && n != 0;
        hg = n != 0 && (stall || !(pwe && pwa != 0));
        pg = !hg && pwe && pwa != 0;
        accepted = sv && n != 2;
        m_we = hg || pg;
        if (hg) begin
            m_wa = m_q[0].wa;
            m_wd = m_q[0].wd;
            void'(m_q.pop_front());
        end else if (pg) begin
            m_wa = pwa;
            m_wd = pwd;
        end
        m_wait = (n == 0 || hg) ? 0 : (m_wait == MW ? MW : m_wait + 1);
        if (accepted && swa != 0) m_q.push_back({swa, swd});
        e.we = m_we; e.wa = m_wa; e.wd = m_wd;
        e.pend = 2'(m_q.size());
        e.rdy = m_q.size() != 2;
        e.stall = GUARD && m_wait == MW && m_q.size() != 0;
        sb.push_back(e);
        @(negedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, acc);
    endtask

    task automatic do_reset();
        p_we = 0; s_valid = 0; p_wa = 0; s_wa = 0; p_wd = 0; s_wd = 0;
        reset_n = 1'b0;
        #1;
        chk("rst_rf_we", rf_we, 0);
        chk("rst_rf_wa", rf_wa, 0);
        chk("rst_rf_wd", rf_wd, 0);
        chk("rst_pend", pend_cnt, 0);
        chk("rst_s_ready", s_ready, 1);
        chk("rst_p_stall", p_stall, 0);
        m_q.delete();
        m_wait = 0; m_we = 0; m_wa = 0; m_wd = 0;
        @(posedge clk); #1;
        chk("rst_hold_we", rf_we, 0);
        @(negedge clk); #1;
        reset_n = 1'b1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("rf_we", rf_we, e.we);
            chk("rf_wa", rf_wa, e.wa);
            chk("rf_wd", rf_wd, e.wd);
            chk("pend_cnt", pend_cnt, e.pend);
            chk("s_ready", s_ready, e.rdy);
            chk("p_stall", p_stall, e.stall);
        end
    end

    initial begin
        int idx;
        logic [4:0] swa_t [3];
        swa_t[0] = 5'd9; swa_t[1] = 5'd10; swa_t[2] = 5'd11;
        #2;
        do_reset();
        cyc(1, 5, 32'h0000_1234, 0, 0, 0, acc);
        idle(2);
        cyc(0, 0, 0, 1, 7, 32'hDEAD_BEEF, acc);
        idle(2);
        idx = 0;
        for (int i = 0; i < 14; i++) begin
            cyc(1, 3, 32'h3000 + i, idx < 3, swa_t[idx % 3], 32'hA000 + idx, acc);
            if (acc && idx < 3) idx++;
        end
        idle(4);
        cyc(1, 3, 32'h5000, 1, 12, 32'hCAFE_0012, acc);
        for (int i = 1; i < 10; i++) cyc(1, 3, 32'h5000 + i, 0, 0, 0, acc);
        idle(3);
        cyc(1, 0, 32'h0BAD_0000, 0, 0, 0, acc);
        cyc(0, 0, 0, 1, 0, 32'h0BAD_0001, acc);
        idle(2);
        cyc(1, 4, 32'h4444, 1, 13, 32'h1313, acc);
        cyc(1, 4, 32'h4445, 1, 14, 32'h1414, acc);
        cyc(1, 4, 32'h4446, 0, 0, 0, acc);
        do_reset();
        idle(3);
        for (int i = 0; i < 2000; i++) begin
            if (i == 1000) do_reset();
            cyc($urandom_range(0, 9) < 7, 5'($urandom_range(0, 31)), $urandom,
                $urandom_range(0, 9) < 4, 5'($urandom_range(0, 31)), $urandom, acc);
        end
        idle(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
